// File: rtl/gzip_ctrl_pkg.sv
// Shared definitions for the Deflate job sequencer: state encoding, block
// type codes and default timing parameters.
package gzip_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CRST  = 3'd1,
        ST_FEED  = 3'd2,
        ST_DRAIN = 3'd3,
        ST_DONE  = 3'd4
    } ctrl_state_e;

    localparam logic [1:0] BTYPE_STORED = 2'b00;
    localparam logic [1:0] BTYPE_FIXED  = 2'b01;

    localparam int DEF_RST_CYCLES     = 4;
    localparam int DEF_TIMEOUT_CYCLES = 65536;

    // Only stored and fixed-Huffman blocks are supported by the core.
    function automatic logic btype_ok(input logic [1:0] bt);
        return (bt == BTYPE_STORED) || (bt == BTYPE_FIXED);
    endfunction

endpackage

// File: rtl/gzip_job_ctrl.sv
// Job sequencer for the Deflate core: resets the core, meters ceil(len/4)
// source words into it, then waits for completion under a timeout.
module gzip_job_ctrl
    import gzip_ctrl_pkg::*;
#(
    parameter int LEN_WIDTH      = 24,
    parameter int RST_CYCLES     = DEF_RST_CYCLES,
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
    parameter int TO_WIDTH       = 17
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 cmd_valid,
    output logic                 cmd_ready,
    input  logic [1:0]           cmd_btype,
    input  logic [LEN_WIDTH-1:0] cmd_len,
    input  logic                 abort,
    output logic                 core_rst_n,
    output logic [1:0]           core_btype,
    input  logic                 src_empty,
    input  logic [31:0]          src_data,
    output logic                 src_rd_en,
    input  logic                 core_full,
    output logic                 core_wr_en,
    output logic [31:0]          core_data,
    output logic                 core_last,
    output logic [1:0]           core_last_bytes,
    input  logic                 core_done,
    output logic                 busy,
    output logic                 done_pulse,
    output logic                 abort_pulse,
    output logic                 err_timeout,
    output logic                 err_cmd,
    output logic [LEN_WIDTH-3:0] words_sent
);

    // One extra bit over words_sent so a maximum-length job cannot overflow.
    localparam int WC_W = LEN_WIDTH - 1;
    localparam int WS_W = LEN_WIDTH - 2;

    localparam logic [WC_W-1:0]     WC_ONE  = {{(WC_W-1){1'b0}}, 1'b1};
    localparam logic [WS_W-1:0]     WS_ONE  = {{(WS_W-1){1'b0}}, 1'b1};
    localparam logic [TO_WIDTH-1:0] TO_ONE  = {{(TO_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [TO_WIDTH-1:0] TO_LAST = TO_WIDTH'(TIMEOUT_CYCLES - 1);
    localparam logic [7:0]          RC_LAST = 8'(RST_CYCLES - 1);
    localparam logic [LEN_WIDTH:0]  LEN_RND = {{(LEN_WIDTH-1){1'b0}}, 2'b11};

    ctrl_state_e         state_r;
    logic [7:0]          rst_cnt_r;
    logic [TO_WIDTH-1:0] to_cnt_r;
    logic [WC_W-1:0]     rem_r;
    logic [1:0]          last_bytes_r;
    logic                cmd_ready_r;
    logic                core_rst_n_r;
    logic [1:0]          core_btype_r;
    logic                done_pulse_r;
    logic                abort_pulse_r;
    logic                err_timeout_r;
    logic                err_cmd_r;
    logic [WS_W-1:0]     words_sent_r;

    logic                cmd_fire_s;
    logic                cmd_ok_s;
    logic                xfer_s;
    logic                rem_last_s;
    logic [LEN_WIDTH:0]  len_pad_s;
    logic [WC_W-1:0]     word_cnt_s;

    // Handshake decode, word-count rounding and the combinational transfer strobe.
    always_comb begin
        cmd_fire_s = cmd_valid & cmd_ready_r;
        cmd_ok_s   = btype_ok(cmd_btype) && (cmd_len != {LEN_WIDTH{1'b0}});
        len_pad_s  = {1'b0, cmd_len} + LEN_RND;
        word_cnt_s = WC_W'(len_pad_s >> 2);
        rem_last_s = (rem_r == WC_ONE);
        // Abort wins over a transfer in the same cycle.
        if (state_r == ST_FEED) begin
            xfer_s = ~src_empty & ~core_full & ~abort;
        end else begin
            xfer_s = 1'b0;
        end
    end

    assign cmd_ready       = cmd_ready_r;
    assign core_rst_n      = core_rst_n_r;
    assign core_btype      = core_btype_r;
    assign src_rd_en       = xfer_s;
    assign core_wr_en      = xfer_s;
    assign core_data       = src_data;
    assign core_last       = xfer_s & rem_last_s;
    assign core_last_bytes = (xfer_s & rem_last_s) ? last_bytes_r : 2'b00;
    assign busy            = (state_r != ST_IDLE);
    assign done_pulse      = done_pulse_r;
    assign abort_pulse     = abort_pulse_r;
    assign err_timeout     = err_timeout_r;
    assign err_cmd         = err_cmd_r;
    assign words_sent      = words_sent_r;

    // Job sequencing FSM with its counters and registered status outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r       <= ST_IDLE;
            rst_cnt_r     <= 8'd0;
            to_cnt_r      <= {TO_WIDTH{1'b0}};
            rem_r         <= {WC_W{1'b0}};
            last_bytes_r  <= 2'b00;
            cmd_ready_r   <= 1'b0;
            core_rst_n_r  <= 1'b0;
            core_btype_r  <= 2'b00;
            done_pulse_r  <= 1'b0;
            abort_pulse_r <= 1'b0;
            err_timeout_r <= 1'b0;
            err_cmd_r     <= 1'b0;
            words_sent_r  <= {WS_W{1'b0}};
        end else begin
            done_pulse_r  <= 1'b0;
            abort_pulse_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    core_rst_n_r <= 1'b1;
                    cmd_ready_r  <= 1'b1;
                    if (cmd_fire_s && cmd_ok_s) begin
                        state_r       <= ST_CRST;
                        cmd_ready_r   <= 1'b0;
                        core_rst_n_r  <= 1'b0;
                        core_btype_r  <= cmd_btype;
                        rem_r         <= word_cnt_s;
                        last_bytes_r  <= cmd_len[1:0];
                        words_sent_r  <= {WS_W{1'b0}};
                        err_timeout_r <= 1'b0;
                        err_cmd_r     <= 1'b0;
                        rst_cnt_r     <= 8'd0;
                    end else if (cmd_fire_s) begin
                        err_cmd_r <= 1'b1;
                    end else begin
                        err_cmd_r <= err_cmd_r;
                    end
                end
                ST_CRST: begin
                    if (abort) begin
                        state_r       <= ST_IDLE;
                        cmd_ready_r   <= 1'b1;
                        core_rst_n_r  <= 1'b0;
                        abort_pulse_r <= 1'b1;
                    end else if (rst_cnt_r == RC_LAST) begin
                        state_r      <= ST_FEED;
                        core_rst_n_r <= 1'b1;
                    end else begin
                        rst_cnt_r <= rst_cnt_r + 8'd1;
                    end
                end
                ST_FEED: begin
                    if (abort) begin
                        state_r       <= ST_IDLE;
                        cmd_ready_r   <= 1'b1;
                        core_rst_n_r  <= 1'b0;
                        abort_pulse_r <= 1'b1;
                    end else if (xfer_s) begin
                        rem_r        <= rem_r - WC_ONE;
                        words_sent_r <= words_sent_r + WS_ONE;
                        if (rem_last_s) begin
                            state_r  <= ST_DRAIN;
                            to_cnt_r <= {TO_WIDTH{1'b0}};
                        end else begin
                            state_r <= ST_FEED;
                        end
                    end else begin
                        state_r <= ST_FEED;
                    end
                end
                ST_DRAIN: begin
                    if (abort) begin
                        state_r       <= ST_IDLE;
                        cmd_ready_r   <= 1'b1;
                        core_rst_n_r  <= 1'b0;
                        abort_pulse_r <= 1'b1;
                    end else if (core_done) begin
                        state_r      <= ST_DONE;
                        done_pulse_r <= 1'b1;
                    end else if (to_cnt_r == TO_LAST) begin
                        state_r       <= ST_IDLE;
                        cmd_ready_r   <= 1'b1;
                        core_rst_n_r  <= 1'b0;
                        err_timeout_r <= 1'b1;
                    end else begin
                        to_cnt_r <= to_cnt_r + TO_ONE;
                    end
                end
                ST_DONE: begin
                    state_r     <= ST_IDLE;
                    cmd_ready_r <= 1'b1;
                end
                default: begin
                    state_r      <= ST_IDLE;
                    cmd_ready_r  <= 1'b1;
                    core_rst_n_r <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_gzip_job_ctrl.sv
// Directed bench for gzip_job_ctrl: a table of whole jobs plus hand-written
// backpressure, abort, timeout and async-reset sequences.
module tb_gzip_job_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [1:0]  cmd_btype;
    logic [23:0] cmd_len;
    logic        abort;
    logic        core_rst_n;
    logic [1:0]  core_btype;
    logic        src_empty;
    logic [31:0] src_data;
    logic        src_rd_en;
    logic        core_full;
    logic        core_wr_en;
    logic [31:0] core_data;
    logic        core_last;
    logic [1:0]  core_last_bytes;
    logic        core_done;
    logic        busy;
    logic        done_pulse;
    logic        abort_pulse;
    logic        err_timeout;
    logic        err_cmd;
    logic [21:0] words_sent;

    gzip_job_ctrl #(
        .LEN_WIDTH(24), .RST_CYCLES(4), .TIMEOUT_CYCLES(64), .TO_WIDTH(17)
    ) dut (
        .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_btype(cmd_btype), .cmd_len(cmd_len), .abort(abort),
        .core_rst_n(core_rst_n), .core_btype(core_btype),
        .src_empty(src_empty), .src_data(src_data), .src_rd_en(src_rd_en),
        .core_full(core_full), .core_wr_en(core_wr_en), .core_data(core_data),
        .core_last(core_last), .core_last_bytes(core_last_bytes),
        .core_done(core_done), .busy(busy), .done_pulse(done_pulse),
        .abort_pulse(abort_pulse), .err_timeout(err_timeout), .err_cmd(err_cmd),
        .words_sent(words_sent)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;

    // Source FIFO model: pops counted on the clock edge, head relative to base.
    logic [31:0] fifo [0:15];
    int   pops = 0;
    int   base = 0;
    int   fifo_n = 0;
    int   head_s;
    logic force_empty = 1'b0;
    int   cyc = 0;

    assign head_s    = pops - base;
    assign src_empty = force_empty || (head_s >= fifo_n);
    assign src_data  = fifo[head_s[3:0]];

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (src_rd_en) pops <= pops + 1;
    end

    int n_wr, n_rstlow, n_done, exp_words, first_wr_cyc, last_wr_cyc;
    logic [1:0] exp_lb;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Write monitor, sampled mid-cycle.
    always @(negedge clk) begin
        if (core_wr_en) begin
            chk("wr_gate", {30'd0, core_full, src_empty}, 32'd0);
            chk("wr_data", core_data, fifo[head_s[3:0]]);
            chk("wr_last", 32'(core_last), 32'(n_wr + 1 == exp_words));
            chk("wr_lbytes", 32'(core_last_bytes), (n_wr + 1 == exp_words) ? 32'(exp_lb) : 32'd0);
            if (n_wr == 0) first_wr_cyc = cyc;
            last_wr_cyc = cyc;
            n_wr++;
        end
        if (!core_rst_n) n_rstlow++;
        if (done_pulse) n_done++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_fifo(input int n);
        base   = pops;
        fifo_n = n;
        for (int i = 0; i < 16; i++) fifo[i] = $urandom();
    endtask

    task automatic start_job(input int words, input logic [1:0] lb, input int nfifo);
        n_wr = 0; n_rstlow = 0; n_done = 0;
        exp_words = words; exp_lb = lb;
        load_fifo(nfifo);
    endtask

    task automatic issue(input logic [1:0] bt, input logic [23:0] ln);
        cmd_btype = bt; cmd_len = ln; cmd_valid = 1'b1;
        tick();
        cmd_valid = 1'b0;
    endtask

    task automatic wait_wr(input int n, input int budget);
        for (int i = 0; i < budget && n_wr < n; i++) tick();
    endtask

    task automatic finish_job(input int words);
        core_done = 1'b1;
        tick();
        core_done = 1'b0;
        chk("done_pulse_hi", 32'(done_pulse), 32'd1);
        tick();
        chk("done_pulse_lo", 32'(done_pulse), 32'd0);
        chk("done_idle", {30'd0, busy, cmd_ready}, 32'd1);
        chk("done_count", 32'(n_done), 32'd1);
        chk("done_words", 32'(words_sent), 32'(words));
    endtask

    typedef struct {
        logic [1:0]  bt;
        logic [23:0] len;
        int          words;
        logic [1:0]  lb;
        bit          rej;
    } vec_t;

    vec_t vecs [8];
    vec_t v;
    int   acc;
    int   t_to;

    initial begin
        vecs[0] = '{2'b01, 24'd10, 3, 2'd2, 1'b0};
        vecs[1] = '{2'b10, 24'd8,  0, 2'd0, 1'b1};
        vecs[2] = '{2'b00, 24'd1,  1, 2'd1, 1'b0};
        vecs[3] = '{2'b01, 24'd0,  0, 2'd0, 1'b1};
        vecs[4] = '{2'b00, 24'd4,  1, 2'd0, 1'b0};
        vecs[5] = '{2'b01, 24'd5,  2, 2'd1, 1'b0};
        vecs[6] = '{2'b11, 24'd4,  0, 2'd0, 1'b1};
        vecs[7] = '{2'b00, 24'd7,  2, 2'd3, 1'b0};

        rst_n = 1'b0; cmd_valid = 1'b0; cmd_btype = 2'b00; cmd_len = 24'd0;
        abort = 1'b0; core_full = 1'b0; core_done = 1'b0;
        load_fifo(0);
        repeat (3) @(posedge clk);
        #1;
        chk("rst_core_rst_n", 32'(core_rst_n), 32'd0);
        chk("rst_cmd_ready", 32'(cmd_ready), 32'd0);
        chk("rst_flags", {26'd0, busy, done_pulse, abort_pulse, err_timeout, err_cmd, src_rd_en}, 32'd0);
        chk("rst_words", 32'(words_sent), 32'd0);
        chk("rst_btype", 32'(core_btype), 32'd0);
        rst_n = 1'b1;
        tick();
        chk("idle_ready", {30'd0, cmd_ready, core_rst_n}, 32'd3);

        // Table of whole jobs and rejected commands.
        for (int k = 0; k < 8; k++) begin
            v = vecs[k];
            start_job(v.words, v.lb, v.rej ? 0 : v.words + 2);
            acc = cyc;
            issue(v.bt, v.len);
            if (v.rej) begin
                chk("rej_err_cmd", 32'(err_cmd), 32'd1);
                chk("rej_idle", {30'd0, busy, cmd_ready}, 32'd1);
                repeat (3) tick();
                chk("rej_core_untouched", 32'(n_rstlow), 32'd0);
            end else begin
                chk("acc_errs_clear", {30'd0, err_cmd, err_timeout}, 32'd0);
                chk("acc_busy", {30'd0, busy, cmd_ready}, 32'd2);
                wait_wr(v.words, 60);
                repeat (4) tick();
                chk("job_writes", 32'(n_wr), 32'(v.words));
                chk("job_pops", 32'(pops - base), 32'(v.words));
                chk("job_latency", 32'(first_wr_cyc - acc), 32'd5);
                chk("job_back_to_back", 32'(last_wr_cyc - first_wr_cyc), 32'(v.words - 1));
                chk("job_crst_len", 32'(n_rstlow), 32'd4);
                chk("job_btype", 32'(core_btype), 32'(v.bt));
                chk("job_drain_busy", 32'(busy), 32'd1);
                repeat (16) tick();
                finish_job(v.words);
            end
        end

        // Backpressure: core_full toggles, source runs dry for three cycles.
        start_job(4, 2'd0, 4);
        issue(2'b00, 24'd16);
        for (int i = 0; i < 40; i++) begin
            core_full   = i[0];
            force_empty = (i >= 7) && (i < 10);
            tick();
        end
        core_full = 1'b0; force_empty = 1'b0;
        chk("bp_writes", 32'(n_wr), 32'd4);
        chk("bp_pops", 32'(pops - base), 32'd4);
        chk("bp_words", 32'(words_sent), 32'd4);
        finish_job(4);

        // Abort on the cycle of the second eligible word.
        start_job(5, 2'd0, 5);
        issue(2'b01, 24'd20);
        wait_wr(1, 40);
        chk("ab_first_wr", 32'(n_wr), 32'd1);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("ab_pulse", 32'(abort_pulse), 32'd1);
        chk("ab_core_rst", 32'(core_rst_n), 32'd0);
        chk("ab_idle", {30'd0, busy, cmd_ready}, 32'd1);
        tick();
        chk("ab_core_rst_rel", 32'(core_rst_n), 32'd1);
        chk("ab_pulse_lo", 32'(abort_pulse), 32'd0);
        chk("ab_writes", 32'(n_wr), 32'd1);
        chk("ab_pops", 32'(pops - base), 32'd1);
        chk("ab_no_done", 32'(n_done), 32'd0);

        // Abort while idle has no effect.
        abort = 1'b1;
        tick();
        tick();
        chk("ab_idle_ignored", {30'd0, abort_pulse, busy}, 32'd0);
        abort = 1'b0;

        // Timeout: one word, core_done never arrives.
        start_job(1, 2'd0, 1);
        issue(2'b01, 24'd4);
        t_to = -1;
        for (int i = 0; i < 200; i++) begin
            tick();
            if (err_timeout) begin
                t_to = cyc;
                break;
            end
        end
        chk("to_delay", 32'(t_to - last_wr_cyc), 32'd65);
        chk("to_core_rst", 32'(core_rst_n), 32'd0);
        chk("to_idle", {30'd0, busy, cmd_ready}, 32'd1);
        chk("to_no_done", 32'(n_done), 32'd0);
        tick();
        chk("to_core_rst_rel", {30'd0, core_rst_n, err_timeout}, 32'd3);
        start_job(2, 2'd0, 2);
        issue(2'b00, 24'd8);
        chk("to_err_cleared", {30'd0, err_timeout, busy}, 32'd1);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("ab_crst_pulse", {30'd0, abort_pulse, busy}, 32'd2);

        // Asynchronous reset in the middle of FEED.
        start_job(6, 2'd0, 6);
        tick();
        issue(2'b01, 24'd24);
        wait_wr(2, 40);
        #2;
        rst_n = 1'b0;
        #1;
        chk("ar_core_rst", 32'(core_rst_n), 32'd0);
        chk("ar_strobes", {28'd0, cmd_ready, busy, core_wr_en, src_rd_en}, 32'd0);
        chk("ar_words", 32'(words_sent), 32'd0);
        chk("ar_btype", 32'(core_btype), 32'd0);
        tick();
        rst_n = 1'b1;
        tick();
        chk("ar_idle", {29'd0, cmd_ready, busy, core_rst_n}, 32'd5);
        chk("ar_words_after", 32'(words_sent), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, expected finish before t=200000");
        $fatal(1);
    end

endmodule

// File: doc/gzip_job_ctrl.md
Name: gzip_job_ctrl

Overview:
- Job sequencer for the Deflate core, in the core clock domain, between the register block/host command path and gzip_top.
- Accepts one compression job per command (block type and byte length). Pulses the core's reset, latches btype, then meters exactly ceil(len/4) 32-bit words from the source FIFO into the core and flags the last word with its valid-byte count.
- Waits for core completion under a timeout and reports done, abort and error status.

Parameters:
- LEN_WIDTH, 24, width of the job byte-length field.
- RST_CYCLES, 4, number of cycles core_rst_n is held low at job start (1..255).
- TIMEOUT_CYCLES, 65536, maximum number of cycles in DRAIN waiting for core_done.
- TO_WIDTH, 17, counter width; must hold TIMEOUT_CYCLES.

Ports:
- clk  in  1  core clock; all logic on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- cmd_valid  in  1  job command present.
- cmd_ready  out  1  controller can accept a command (high only in IDLE).
- cmd_btype  in  2  00 stored, 01 fixed Huffman; other codes are rejected.
- cmd_len  in  LEN_WIDTH  job length in bytes.
- abort  in  1  cancel the current job.
- core_rst_n  out  1  active-low reset to the Deflate core.
- core_btype  out  2  btype to the core, held for the whole job.
- src_empty  in  1  source FIFO empty (first-word-fall-through).
- src_data  in  32  source FIFO head word.
- src_rd_en  out  1  pop the source FIFO.
- core_full  in  1  core input cannot accept a word.
- core_wr_en  out  1  word write strobe to the core.
- core_data  out  32  word to the core.
- core_last  out  1  qualifies core_wr_en: this is the final word.
- core_last_bytes  out  2  valid bytes in the final word; 0 means 4.
- core_done  in  1  single-cycle pulse from the core: stream flushed.
- busy  out  1  high in any state except IDLE.
- done_pulse  out  1  one cycle high when a job completes normally.
- abort_pulse  out  1  one cycle high when an abort is taken.
- err_timeout  out  1  sticky; cleared when the next command is accepted.
- err_cmd  out  1  sticky; set on rejected command; cleared when the next valid command is accepted.
- words_sent  out  LEN_WIDTH-2  words written in the current or last job.

Behaviour:
- Reset values:
  - core_rst_n=0 and core_btype=00.
  - cmd_ready=0 during reset, 1 in IDLE after reset.
  - All strobes, pulses and errors 0; words_sent=0.
- States:
  - IDLE: core_rst_n=1, cmd_ready=1.
  - CRST: core_rst_n=0 for exactly RST_CYCLES cycles.
  - FEED.
  - DRAIN.
  - DONE: one cycle, done_pulse=1.
- Command handshake: accept on cmd_valid&cmd_ready.
  - Rejected if cmd_btype not in {00,01} or cmd_len==0: set err_cmd, stay in IDLE, core untouched.
  - Otherwise:
    - Latch btype, set core_btype next cycle.
    - Load the remaining-word counter with (cmd_len+3)>>2 and latch last_bytes=cmd_len[1:0].
    - Clear words_sent and err_timeout/err_cmd.
    - Go to CRST.
- CRST -> FEED after RST_CYCLES cycles; core_rst_n returns to 1 on FEED entry.
- FEED:
  - Transfer condition is combinational: xfer = ~src_empty & ~core_full.
  - When xfer is true: src_rd_en = core_wr_en = 1 and core_data = src_data.
  - Each xfer decrements the remaining counter and increments words_sent.
  - core_last=1 with the xfer where remaining==1; core_last_bytes=last_bytes on that cycle, else 0.
  - After the last xfer -> DRAIN.
  - Throughput: one word per cycle when unstalled; no bubbles on stall release.
- DRAIN:
  - Timeout counter starts at 0 on entry.
  - core_done -> DONE.
  - Counter reaching TIMEOUT_CYCLES-1 without core_done: set err_timeout, drive core_rst_n=0 for one cycle, go to IDLE (no done_pulse).
  - core_done seen in FEED is ignored.
- DONE -> IDLE.
- Latency:
  - Command accept to first possible core_wr_en = RST_CYCLES+1 cycles.
  - core_done to done_pulse = 1 cycle.
- Abort:
  - Applies in CRST, FEED or DRAIN; abort in IDLE or DONE is ignored.
  - Next cycle: core_rst_n=0 for one cycle, abort_pulse=1, state IDLE, no further src_rd_en.
  - Abort beats an xfer in the same cycle: no write that cycle.
  - Source FIFO contents are left for software to flush.
- Length limits:
  - cmd_len at max value: word count uses LEN_WIDTH-1 bits internally, so there is no overflow.
  - Single-word job (len 1..4): first xfer carries core_last.
- rst_n mid-job: immediate return to reset values; core held in reset.

Decomposition:
- Shared package gzip_ctrl_pkg:
  - State enum encoding (IDLE, CRST, FEED, DRAIN, DONE).
  - BTYPE_STORED=2'b00 and BTYPE_FIXED=2'b01 constants.
  - Default RST_CYCLES and TIMEOUT_CYCLES.
- Sub-module: none required; counters are inline. The FSM and datapath fit in one module.

Test Plan:
- Basic job:
  - Stimulus: cmd btype=01, len=10, FIFO preloaded with 3 words, core_full=0.
  - Response: core_rst_n low 4 cycles; 3 consecutive core_wr_en; third has core_last=1 and core_last_bytes=2; core_done 20 cycles later -> done_pulse 1 cycle after; words_sent=3.
- Backpressure:
  - Stimulus: len=16, core_full toggled every other cycle, src_empty high for 3 cycles mid-stream.
  - Response: exactly 4 writes; no write when core_full=1 or src_empty=1; last word has last_bytes=0.
- Rejected commands:
  - Stimulus: btype=10, then len=0.
  - Response: err_cmd=1 each time; core_rst_n stays 1; busy stays 0.
  - Follow-up: a valid command clears err_cmd.
- Abort:
  - Stimulus: abort asserted in the same cycle as the 2nd of 5 xfer-eligible words.
  - Response: no write that cycle; abort_pulse=1; core_rst_n low 1 cycle; IDLE; cmd_ready=1; no done_pulse.
- Timeout:
  - Stimulus: TIMEOUT_CYCLES=64, core_done never asserted.
  - Response: err_timeout set 64 cycles after DRAIN entry; core_rst_n pulsed; IDLE. err_timeout clears on the next command accept.
- Async reset:
  - Stimulus: rst_n low during FEED.
  - Response: outputs go to reset values immediately; after release, IDLE with cmd_ready=1 and words_sent=0.
